// File: rtl/noise_icdf_gen.sv
// noise_icdf_gen: inverse-CDF noise generator. A uniform word is mapped to a
// bin by binary search over a loadable CDF table; the result is idx - OFFSET.
// Ports: clk, rstn (sync, active-low)
//   in_valid/in_ready   : request with rand_in, sig_in, add_en
//   out_valid/out_ready : result noise_out, out_data, out_sat
//   cfg_we/cfg_ready    : table write of cfg_data at cfg_addr (IDLE only)
module noise_icdf_gen #(
  parameter int NBINS    = 128,
  parameter int RAND_W   = 64,
  parameter int OUT_W    = 8,
  parameter int OFFSET   = 63,
  parameter     CDF_FILE = "",
  localparam int L       = $clog2(NBINS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [RAND_W-1:0]       rand_in,
  input  logic signed [OUT_W-1:0] sig_in,
  input  logic                    add_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] noise_out,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat,
  input  logic                    cfg_we,
  input  logic [L-1:0]            cfg_addr,
  input  logic [RAND_W-1:0]       cfg_data,
  output logic                    cfg_ready
);

  localparam int AW = ((L > OUT_W) ? L : OUT_W) + 2;
  localparam logic signed [AW-1:0] MAXV =
    AW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [RAND_W-1:0] cdf [NBINS];

  logic [RAND_W-1:0]       rnd;
  logic signed [OUT_W-1:0] sig;
  logic                    add;
  logic [L-1:0]            lo, hi, step, mid;
  logic [L:0]              sum_lh;
  logic                    accept, last, go_right;

  logic signed [AW-1:0] n_w, n_clip, s_w, s_clip, sig_w;
  logic signed [AW-1:0] res;
  logic                 n_ovf, s_ovf, res_sat;

  assign in_ready  = (state == IDLE) && !cfg_we;
  assign cfg_ready = (state == IDLE);
  assign accept    = in_valid && in_ready;

  assign sum_lh   = {1'b0, lo} + {1'b0, hi};
  assign mid      = L'(sum_lh >> 1);
  assign go_right = !(rnd < cdf[mid]);
  assign last     = (step == L'(L - 1));

  // Table is not reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (rstn && cfg_we && cfg_ready)
      cdf[cfg_addr] <= cfg_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SEARCH;
      SEARCH:  if (last) state_nxt = DONE;
      DONE:    if (out_valid && out_ready)
                 state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // lo holds the selected bin once the search is over; a full-range
  // search of L halvings always ends with lo == hi, so a word above the
  // last threshold lands on NBINS-1.
  always_comb begin
    n_w    = $signed({{(AW-L){1'b0}}, lo})
           - $signed(AW'(OFFSET));
    n_clip = n_w;
    n_ovf  = 1'b0;
    if (n_w > MAXV) begin
      n_clip = MAXV;
      n_ovf  = 1'b1;
    end else if (n_w < MINV) begin
      n_clip = MINV;
      n_ovf  = 1'b1;
    end
    sig_w  = {{(AW-OUT_W){sig[OUT_W-1]}}, sig};
    s_w    = sig_w + n_clip;
    s_clip = s_w;
    s_ovf  = 1'b0;
    if (s_w > MAXV) begin
      s_clip = MAXV;
      s_ovf  = 1'b1;
    end else if (s_w < MINV) begin
      s_clip = MINV;
      s_ovf  = 1'b1;
    end
    res     = add ? s_clip : n_clip;
    res_sat = n_ovf || (add && s_ovf);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      noise_out <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            rnd  <= rand_in;
            sig  <= sig_in;
            add  <= add_en;
            lo   <= '0;
            hi   <= '1;
            step <= '0;
          end
        end
        SEARCH: begin
          if (go_right) lo <= mid + 1'b1;
          else          hi <= mid;
          step <= step + 1'b1;
        end
        DONE: begin
          // First DONE cycle registers the result; then hold.
          if (!out_valid) begin
            out_valid <= 1'b1;
            noise_out <= OUT_W'(n_clip);
            out_data  <= OUT_W'(res);
            out_sat   <= res_sat;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_noise_icdf_gen.sv
// tb_noise_icdf_gen: scoreboard bench for noise_icdf_gen.
// Linear CDF table, directed requests with hand-computed results.
module tb_noise_icdf_gen;

  localparam int L = 7;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid, in_ready;
  logic [63:0]       rand_in;
  logic signed [7:0] sig_in;
  logic              add_en;
  logic              out_valid, out_ready;
  logic signed [7:0] noise_out, out_data;
  logic              out_sat;
  logic              cfg_we, cfg_ready;
  logic [6:0]        cfg_addr;
  logic [63:0]       cfg_data;

  typedef struct {
    logic signed [7:0] n;
    logic signed [7:0] d;
    logic              s;
    int                acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   prev_ov = 1'b0;

  noise_icdf_gen dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rand_in   (rand_in),
    .sig_in    (sig_in),
    .add_en    (add_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .noise_out (noise_out),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_ready (cfg_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) fail("spurious_valid");
        else chk("latency", cyc - q[0].acc, L + 1);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = q.pop_front();
          chk("noise_out", noise_out, e.n);
          chk("out_data", out_data, e.d);
          chk("out_sat", out_sat, e.s);
        end
      end
      prev_ov = out_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [63:0] r,
                      input logic signed [7:0] s,
                      input bit a,
                      input logic signed [7:0] en,
                      input logic signed [7:0] ed,
                      input bit es);
    bit rdy;
    int n;
    in_valid = 1'b1;
    rand_in  = r;
    sig_in   = s;
    add_en   = a;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 100);
    #1;
    in_valid = 1'b0;
    if (!rdy) fail("accept_timeout");
    else q.push_back('{n: en, d: ed, s: es, acc: cyc});
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      fail("result_timeout");
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    rand_in   = '0;
    sig_in    = '0;
    add_en    = 1'b0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_noise_out", noise_out, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_ready", cfg_ready, 1);

    // Linear table: cdf[i] = (i+1) << 57, last entry all-ones.
    @(posedge clk);
    #1;
    cfg_we = 1'b1;
    for (int i = 0; i < 128; i++) begin
      cfg_addr = 7'(i);
      cfg_data = (i == 127) ? '1 : (64'(i + 1) << 57);
      @(posedge clk);
      #1;
    end
    cfg_we = 1'b0;

    // Config write in IDLE blocks acceptance that cycle.
    cfg_we   = 1'b1;
    cfg_addr = 7'd0;
    cfg_data = 64'd1 << 57;
    in_valid = 1'b1;
    @(negedge clk);
    chk("cfg_blocks_in_ready", in_ready, 0);
    chk("cfg_ready_idle", cfg_ready, 1);
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;

    // Test 1
    send(64'd0, 8'sd0, 1'b0, -8'sd63, -8'sd63, 1'b0);
    wait_empty();

    // Test 2
    send(64'h8000_0000_0000_0000, 8'sd0, 1'b0,
         8'sd1, 8'sd1, 1'b0);
    wait_empty();
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'sd0, 1'b0,
         8'sd64, 8'sd64, 1'b0);
    wait_empty();

    // Test 3 plus unsaturated adds
    send(64'hFFFF_FFFF_FFFF_FFFF, 8'sd100, 1'b1,
         8'sd64, 8'sd127, 1'b1);
    wait_empty();
    send(64'd0, -8'sd100, 1'b1, -8'sd63, -8'sd128, 1'b1);
    wait_empty();
    send(64'd0, 8'sd10, 1'b1, -8'sd63, -8'sd53, 1'b0);
    wait_empty();
    send(64'h8000_0000_0000_0000, -8'sd5, 1'b1,
         8'sd1, -8'sd4, 1'b0);
    wait_empty();
    // 5<<57 sits exactly on cdf[4], so bin 5 is chosen.
    send(64'd5 << 57, 8'sd0, 1'b0, -8'sd58, -8'sd58, 1'b0);
    wait_empty();

    // Test 4: stall in DONE
    out_ready = 1'b0;
    send(64'd5 << 57, 8'sd0, 1'b0, -8'sd58, -8'sd58, 1'b0);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!out_valid && n < 50);
    end
    chk("t4_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      in_valid = (k % 2 == 0);
      rand_in  = '0;
      @(negedge clk);
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_noise", noise_out, -8'sd58);
      chk("t4_hold_data", out_data, -8'sd58);
      chk("t4_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_empty();

    // Test 5: cfg write during SEARCH is ignored
    send(64'd0, 8'sd0, 1'b0, -8'sd63, -8'sd63, 1'b0);
    cfg_we   = 1'b1;
    cfg_addr = 7'd0;
    cfg_data = 64'd0;
    @(negedge clk);
    chk("t5_cfg_ready", cfg_ready, 0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    wait_empty();
    send(64'd0, 8'sd0, 1'b0, -8'sd63, -8'sd63, 1'b0);
    wait_empty();

    // Test 6: reset at step 3 of SEARCH
    send(64'h8000_0000_0000_0000, 8'sd0, 1'b0,
         8'sd1, 8'sd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    q.delete();
    @(negedge clk);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_out_data", out_data, 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t6_no_output", out_valid, 0);
    @(posedge clk);
    #1;
    send(64'hFFFF_FFFF_FFFF_FFFF, -8'sd10, 1'b1,
         8'sd64, 8'sd54, 1'b0);
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
